// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Function : Multi-port register file with write-to-read bypass and a
//             per-register pending-write scoreboard for RAW stall detection.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]         wr_data,
    input  logic                        iss_valid,
    input  logic [$clog2(NREGS)-1:0]    iss_addr,
    input  logic                        flush,
    output logic [NREGS-1:0]            busy_vec
);

    localparam int AW        = $clog2(NREGS);
    localparam bit c_zero_en = (ZERO_REG != 0);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [AW-1:0]    w_wr_addr [NWR];
    logic [XLEN-1:0]  w_wr_data [NWR];
    logic [NREGS-1:0] w_wr_hit;
    logic [NREGS-1:0] w_iss_hit;
    logic [NREGS-1:0] w_busy_nxt;

    generate
        for (genvar w = 0; w < NWR; w++) begin : g_wr_unpack
            assign w_wr_addr[w] = wr_addr[w*AW +: AW];
            assign w_wr_data[w] = wr_data[w*XLEN +: XLEN];
        end
    endgenerate

    // Later ports are assigned last, so the highest-index port wins a conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && !(c_zero_en && (w_wr_addr[w] == '0))) begin
                    r_regs[w_wr_addr[w]] <= w_wr_data[w];
                end
            end
        end
    end

    always_comb begin
        w_wr_hit = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                w_wr_hit[w_wr_addr[w]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_iss_hit = '0;
        if (iss_valid && !(c_zero_en && (iss_addr == '0))) begin
            w_iss_hit[iss_addr] = 1'b1;
        end
    end

    // A new producer supersedes a completing one; flush overrides everything.
    always_comb begin
        w_busy_nxt = (r_busy & ~w_wr_hit) | w_iss_hit;
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;

            assign w_addr = rd_addr[p*AW +: AW];

            always_comb begin
                w_data = r_regs[w_addr];
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (w_wr_addr[w] == w_addr)) begin
                        w_data = w_wr_data[w];
                    end
                end
                if (c_zero_en && (w_addr == '0)) begin
                    w_data = '0;
                end
            end

            assign rd_data[p*XLEN +: XLEN] = w_data;
            assign rd_busy[p] = r_busy[w_addr] & ~(w_wr_hit[w_addr] & ~w_iss_hit[w_addr]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp_sb
//  Function : Directed self-checking bench for regfile_mp_sb.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;
    logic [63:0] z_rd_data;
    logic [1:0]  z_rd_busy;
    logic [31:0] z_busy_vec;

    int errors;
    int checks;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .busy_vec(busy_vec)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(z_rd_data),
        .rd_busy(z_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .busy_vec(z_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wr_en     = 2'b00;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rd_addr = {5'd5, 5'd5};
        idle();
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL reset_init_data: got %h expected %h", rd_data, 64'h0);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_init_busy: got %h expected %h", busy_vec, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        iss_valid = 1'b1; iss_addr = 5'd3;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++; $display("FAIL reset_prewrite: got %h expected %h", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
        end
        checks++;
        if (busy_vec !== 32'h0000_0008) begin
            errors++; $display("FAIL reset_preissue: got %h expected %h", busy_vec, 32'h8);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL reset_async_data: got %h expected %h", rd_data, 64'h0);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_async_busy: got %h expected %h", busy_vec, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_data !== {32'h22, 32'h22}) begin
            errors++; $display("FAIL dual_bypass: got %h expected %h", rd_data, {32'h22, 32'h22});
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22) begin
            errors++; $display("FAIL dual_stored: got %h expected %h", rd_data[31:0], 32'h22);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        iss_valid = 1'b1; iss_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL zero_bypass: got %h expected %h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (z_rd_data[31:0] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL zero_off_bypass: got %h expected %h", z_rd_data[31:0], 32'hFFFFFFFF);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL zero_stored: got %h expected %h", rd_data[63:32], 32'h0);
        end
        checks++;
        if (busy_vec[0] !== 1'b0) begin
            errors++; $display("FAIL zero_busy: got %b expected %b", busy_vec[0], 1'b0);
        end
        checks++;
        if (z_rd_data[63:32] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL zero_off_stored: got %h expected %h", z_rd_data[63:32], 32'hFFFFFFFF);
        end
        checks++;
        if (z_busy_vec[0] !== 1'b1) begin
            errors++; $display("FAIL zero_off_busy: got %b expected %b", z_busy_vec[0], 1'b1);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd3;
        rd_addr = {5'd0, 5'd3};
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0008) begin
            errors++; $display("FAIL sb_set: got %h expected %h", busy_vec, 32'h8);
        end
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_rd_busy: got %b expected %b", rd_busy[0], 1'b1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0008) begin
            errors++; $display("FAIL sb_hold: got %h expected %h", busy_vec, 32'h8);
        end
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL sb_wb_unblock: got %b expected %b", rd_busy[0], 1'b0);
        end
        checks++;
        if (rd_data[31:0] !== 32'h55) begin
            errors++; $display("FAIL sb_wb_bypass: got %h expected %h", rd_data[31:0], 32'h55);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL sb_clear: got %h expected %h", busy_vec, 32'h0);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd9;
        rd_addr = {5'd0, 5'd9};
        @(negedge clk);
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
        iss_valid = 1'b1; iss_addr = 5'd9;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL coll_rd_busy: got %b expected %b", rd_busy[0], 1'b1);
        end
        checks++;
        if (rd_data[31:0] !== 32'h99) begin
            errors++; $display("FAIL coll_bypass: got %h expected %h", rd_data[31:0], 32'h99);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            errors++; $display("FAIL coll_busy: got %h expected %h", busy_vec, 32'h200);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd2;
        @(negedge clk);
        iss_addr = 5'd4;
        @(negedge clk);
        iss_addr = 5'd6;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0254) begin
            errors++; $display("FAIL flush_pre: got %h expected %h", busy_vec, 32'h254);
        end
        flush = 1'b1;
        iss_valid = 1'b1; iss_addr = 5'd8;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44};
        rd_addr = {5'd4, 5'd4};
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL flush_busy: got %h expected %h", busy_vec, 32'h0);
        end
        checks++;
        if (rd_data !== {32'h44, 32'h44}) begin
            errors++; $display("FAIL flush_write: got %h expected %h", rd_data, {32'h44, 32'h44});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hB0B0_0011, 32'hA0A0_0010};
        rd_addr = {5'd11, 5'd10};
        #1;
        checks++;
        if (rd_data !== {32'hB0B0_0011, 32'hA0A0_0010}) begin
            errors++; $display("FAIL b2b_bypass: got %h expected %h", rd_data, {32'hB0B0_0011, 32'hA0A0_0010});
        end
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h1234_5678};
        #1;
        checks++;
        if (rd_data !== {32'hB0B0_0011, 32'h1234_5678}) begin
            errors++; $display("FAIL b2b_overwrite: got %h expected %h", rd_data, {32'hB0B0_0011, 32'h1234_5678});
        end
        @(negedge clk);
        idle();
        rd_addr = {5'd10, 5'd7};
        #1;
        checks++;
        if (rd_data !== {32'h1234_5678, 32'h22}) begin
            errors++; $display("FAIL b2b_stored: got %h expected %h", rd_data, {32'h1234_5678, 32'h22});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port integer register file with write-to-read bypass and a per-register pending-write scoreboard, for the pipelined core's decode/writeback stages. It provides NRD combinational read ports and NWR synchronous write ports. It tracks which architectural registers have an in-flight producer so decode can stall on RAW hazards. Register 0 can optionally be hardwired to zero.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers, power of two, ≥ 2; AW = log2(NREGS).
- NRD, 2: number of read ports, 1..4.
- NWR, 2: number of write ports, 1..2.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, and is never marked busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- rd_addr  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  1 = addressed register has a pending producer.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_valid  in  1  an instruction with a destination issues this cycle.
- iss_addr  in  AW  destination of the issuing instruction.
- flush  in  1  clear all busy bits; register contents are unaffected.
- busy_vec  out  NREGS  scoreboard state, bit i = register i pending.

## Operation
- **Storage:** NREGS × XLEN flops. While reset = 0, every register is 0 and every busy bit is 0.
- **Write:** on each rising edge, for each port w with wr_en[w]=1 and address ≠ 0 (when ZERO_REG=1), the register takes wr_data[w].
- **Write conflict:** when both ports are enabled to the same address, port 1 wins.
- **Read:** rd_data[p] is selected in this order:
  - 0 if ZERO_REG=1 and the address is 0;
  - else wr_data of the highest-index enabled write port whose address matches (same-cycle bypass);
  - else the stored value.
- **Scoreboard, per register i, next state:**
  - set if iss_valid and iss_addr == i;
  - else clear if any wr_en[w] with wr_addr[w] == i;
  - else hold.
  - Issue beats a same-cycle writeback to the same register, because the new producer supersedes the old one.
- **Busy reporting:** rd_busy[p] = busy[rd_addr[p]] AND NOT (a same-cycle write to that address AND NOT a same-cycle issue to it). A completing write therefore unblocks a same-cycle read.
- **Flush:** flush=1 clears every busy bit on the next edge and takes priority over issue in the same cycle. Writes still occur during flush.
- **Register 0:** with ZERO_REG=1, register 0 is never busy and iss_addr=0 is ignored.
- **Width rules:** write data is stored as given, with no sign or zero extension. Addresses ≥ NREGS are not possible because NREGS is a power of two.

## Timing
- **Read latency:** 0 cycles (combinational from rd_addr, wr_*).
- **Write latency:** data written at edge N is visible from the stored array after edge N. During cycle N it is visible via bypass.
- **Busy latency:** issue at edge N sets busy_vec from N+1; writeback at edge M clears it from M+1, and rd_busy is already clear during cycle M.
- **Reset:** asynchronous assertion immediately forces all state to 0; deassertion is synchronised externally. A reset arriving mid-write discards that write.
- **Outputs after reset:** all outputs are 0 (rd_data=0, rd_busy=0, busy_vec=0).

## Test plan
- **Reset:** write 0xDEADBEEF to x5, then assert reset → every port reads x5 = 0 and busy_vec = 0 immediately, before any clock edge.
- **Dual write conflict:** wr_en=2'b11, both addresses 7, data 0x11 / 0x22 → x7 = 0x22 after the edge. During the cycle, rd_addr=7 returns 0x22 via bypass.
- **Zero register:** write 0xFFFFFFFF to x0 and issue to x0 → x0 reads 0 and busy_vec[0]=0. Repeat with ZERO_REG=0 → x0 reads 0xFFFFFFFF.
- **Scoreboard:** issue x3 at edge 1 → busy_vec[3]=1 from cycle 2. In cycle 4, write x3=0x55 while reading x3 → rd_busy=0 and rd_data=0x55; busy_vec[3]=0 from cycle 5.
- **Issue/writeback collision:** x9 busy; in the same cycle write x9 and issue x9 → busy_vec[9] stays 1 and rd_busy for x9 = 1.
- **Flush:** x2, x4 and x6 busy; assert flush together with an issue to x8 → busy_vec = 0 after the edge, and a write to x4 in the same cycle is still stored.
